// File: rtl/perceptron_train_ctrl_pkg.sv
// Q31.32 fixed-point helpers (FixedPoint) and sequencing/activation types (Common)
// shared by perceptron_train_ctrl and its sfp_mac datapath.
package FixedPoint;
  localparam int unsigned frac_bits = 32;

  typedef logic signed [63:0] sfp;

  function automatic sfp int_to_sfp(input int i);
    return sfp'(i) <<< frac_bits;
  endfunction

  localparam sfp sfp_one = int_to_sfp(1);

  // Full-precision product, rescaled back to Q31.32; upper bits are discarded (wraps).
  function automatic sfp sfp_mul(input sfp a, input sfp b);
    logic signed [127:0] p;
    p = 128'(a) * 128'(b);
    p = p >>> frac_bits;
    return p[63:0];
  endfunction

  function automatic sfp sfp_add(input sfp a, input sfp b);
    return a + b;
  endfunction
endpackage

package Common;
  import FixedPoint::*;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_UPDATE
  } train_state;

  // Activation-select hook; only the Step function exists so far.
  typedef enum logic {ACT_STEP} act_sel;
  localparam act_sel ACT_DEFAULT = ACT_STEP;

  function automatic logic activate(input act_sel sel, input sfp sum);
    logic r;
    case (sel)
      ACT_STEP: r = !sum[63];
      default:  r = !sum[63];
    endcase
    return r;
  endfunction
endpackage

// File: rtl/perceptron_train_ctrl_sfp_mac.sv
// Combinational fixed-point multiply-accumulate: sum = a + sfp_mul(b, c).
module sfp_mac
  import FixedPoint::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [63:0] c,
  output logic [63:0] sum
);
  always_comb sum = sfp_add(a, sfp_mul(b, c));
endmodule

// File: rtl/perceptron_train_ctrl.sv
// Single-perceptron sequencer: serial dot product, Step activation, online weight update.
// Define PERCEPTRON_BIAS_EN to add a bias weight at index N_INPUTS (implicit input 1.0).
module perceptron_train_ctrl
  import FixedPoint::*;
  import Common::*;
#(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned IDX_W    = $clog2(N_INPUTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_INPUTS*64-1:0]   in_x,
  input  logic                     in_target,
  input  logic                     in_train,
  input  logic [63:0]              lr,
  input  logic                     w_wr_en,
  input  logic [IDX_W-1:0]         w_wr_idx,
  input  logic [63:0]              w_wr_data,
  input  logic [IDX_W-1:0]         w_rd_idx,
  output logic [63:0]              w_rd_data,
  output logic                     y_valid,
  output logic                     y,
  output logic [63:0]              acc,
  output logic [31:0]              err_cnt,
  output logic                     busy
);
`ifdef PERCEPTRON_BIAS_EN
  localparam int unsigned N_W = N_INPUTS + 1;
`else
  localparam int unsigned N_W = N_INPUTS;
`endif
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_W - 1);

  train_state              state;
  logic [63:0]             w [N_W];
  logic [N_INPUTS*64-1:0]  x_r;
  logic                    target_r, train_r;
  logic [63:0]             lr_r, lr_err_r, acc_r;
  logic [IDX_W-1:0]        idx;

  logic [63:0] w_cur, x_cur, mac_a, mac_b, mac_out, err_val, lr_err;
  logic        y_next, err_nz;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // Index positions past the real inputs select the implicit 1.0 bias input.
  always_comb begin
    w_cur     = '0;
    x_cur     = sfp_one;
    w_rd_data = '0;
    for (int unsigned i = 0; i < N_W; i++) begin
      if (IDX_W'(i) == idx)      w_cur     = w[i];
      if (IDX_W'(i) == w_rd_idx) w_rd_data = w[i];
    end
    for (int unsigned i = 0; i < N_INPUTS; i++)
      if (IDX_W'(i) == idx) x_cur = x_r[64*i +: 64];
  end

  // One MAC serves both phases: acc += w*x in Compute, w += lr_err*x in Update.
  always_comb begin
    mac_a = (state == S_UPDATE) ? w_cur    : acc_r;
    mac_b = (state == S_UPDATE) ? lr_err_r : w_cur;
  end

  sfp_mac u_mac (
    .a   (mac_a),
    .b   (mac_b),
    .c   (x_cur),
    .sum (mac_out)
  );

  always_comb begin
    y_next  = activate(ACT_DEFAULT, mac_out);
    err_nz  = (target_r != y_next);
    err_val = target_r ? sfp_one : -sfp_one;
    lr_err  = sfp_mul(lr_r, err_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      acc_r    <= '0;
      x_r      <= '0;
      target_r <= 1'b0;
      train_r  <= 1'b0;
      lr_r     <= '0;
      lr_err_r <= '0;
      y        <= 1'b0;
      y_valid  <= 1'b0;
      acc      <= '0;
      err_cnt  <= '0;
      for (int unsigned i = 0; i < N_W; i++) w[i] <= '0;
    end else begin
      y_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (w_wr_en)
            for (int unsigned i = 0; i < N_W; i++)
              if (IDX_W'(i) == w_wr_idx) w[i] <= w_wr_data;
          if (in_valid) begin
            x_r      <= in_x;
            target_r <= in_target;
            train_r  <= in_train;
            lr_r     <= lr;
            acc_r    <= '0;
            idx      <= '0;
            state    <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          acc_r <= mac_out;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            y       <= y_next;
            acc     <= mac_out;
            y_valid <= 1'b1;
            idx     <= '0;
            if (err_nz) err_cnt <= err_cnt + 32'd1;
            if (train_r && err_nz) begin
              lr_err_r <= lr_err;
              state    <= S_UPDATE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_UPDATE: begin
          for (int unsigned i = 0; i < N_W; i++)
            if (IDX_W'(i) == idx) w[i] <= mac_out;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            idx   <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Self-checking bench for perceptron_train_ctrl (N_INPUTS=2); honours PERCEPTRON_BIAS_EN.
module tb_perceptron_train_ctrl;
  localparam int N  = 2;
  localparam int IW = $clog2(N + 1);
`ifdef PERCEPTRON_BIAS_EN
  localparam int NW = N + 1;
`else
  localparam int NW = N;
`endif
  localparam int     T   = NW;
  localparam longint ONE = 64'sh1_0000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*64-1:0] in_x = '0;
  logic            in_target = 1'b0;
  logic            in_train = 1'b0;
  logic [63:0]     lr = '0;
  logic            w_wr_en = 1'b0;
  logic [IW-1:0]   w_wr_idx = '0;
  logic [63:0]     w_wr_data = '0;
  logic [IW-1:0]   w_rd_idx = '0;
  logic [63:0]     w_rd_data;
  logic            y_valid, y, busy;
  logic [63:0]     acc;
  logic [31:0]     err_cnt;

  perceptron_train_ctrl #(.N_INPUTS(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_target(in_target), .in_train(in_train), .lr(lr), .w_wr_en(w_wr_en),
    .w_wr_idx(w_wr_idx), .w_wr_data(w_wr_data), .w_rd_idx(w_rd_idx),
    .w_rd_data(w_rd_data), .y_valid(y_valid), .y(y), .acc(acc),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: weights plus the expected output timeline of the latest sample.
  longint      mw[NW];
  longint      sx[N];
  int          yv_cyc, bs, be;
  bit          y_old, y_new, mon_en;
  longint      acc_old, acc_new;
  int unsigned err_old, err_new;
  int unsigned n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic longint fmul(input longint a, input longint b);
    logic signed [127:0] p;
    p = a;
    p = p * b;
    return longint'(p >>> 32);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NW; i++) mw[i] = 0;
    yv_cyc = -1; bs = 1; be = 0;
    y_old = 0; y_new = 0; acc_old = 0; acc_new = 0; err_old = 0; err_new = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit b;
      b = (cyc >= bs) && (cyc <= be);
      chk("busy", 64'(busy), 64'(b));
      chk("in_ready", 64'(in_ready), 64'(!b));
      chk("y_valid", 64'(y_valid), 64'(cyc == yv_cyc));
      chk("y", 64'(y), 64'((cyc >= yv_cyc) ? y_new : y_old));
      chk("acc", acc, (cyc >= yv_cyc) ? acc_new : acc_old);
      chk("err_cnt", 64'(err_cnt), 64'((cyc >= yv_cyc) ? err_new : err_old));
    end
  end

  task automatic check_weights();
    for (int i = 0; i < (1 << IW); i++) begin
      w_rd_idx = IW'(i);
      #1;
      chk("w_rd", w_rd_data, (i < NW) ? mw[i] : 64'd0);
    end
  endtask

  task automatic rd(input int i, input string name, input logic [63:0] exp);
    w_rd_idx = IW'(i);
    #1;
    chk(name, w_rd_data, exp);
  endtask

  task automatic preload(input int i, input longint d);
    w_wr_en = 1; w_wr_idx = IW'(i); w_wr_data = d;
    @(posedge clk); #1;
    w_wr_en = 0;
    if (i < NW) mw[i] = d;
  endtask

  // Offers sx[] in the current (Idle) cycle and follows it to Idle, or aborts with reset.
  task automatic run_sample(input bit tgt, input bit trn, input longint lrv, input bit wr,
                            input int wr_i, input longint wr_d, input int rst_after,
                            input bit noise);
    int c, idle_c;
    longint s, lr_err;
    bit yy, upd;
    c = cyc;
    for (int i = 0; i < N; i++) in_x[64*i +: 64] = sx[i];
    in_target = tgt; in_train = trn; lr = lrv; in_valid = 1;
    w_wr_en = wr; w_wr_idx = IW'(wr_i); w_wr_data = wr_d;
    if (wr && wr_i < NW) mw[wr_i] = wr_d;
    s = 0;
    for (int i = 0; i < N; i++) s += fmul(mw[i], sx[i]);
    if (NW > N) s += mw[NW-1];
    yy = (s >= 0);
    upd = trn && (tgt != yy);
    lr_err = tgt ? lrv : -lrv;
    y_old = y_new; acc_old = acc_new; err_old = err_new;
    y_new = yy; acc_new = s;
    if (tgt != yy) err_new++;
    yv_cyc = c + T + 1;
    bs = c + 1;
    be = c + T + (upd ? T : 0);
    idle_c = be + 1;
    @(posedge clk); #1;
    in_valid = 0; w_wr_en = 0;
    while (cyc < idle_c) begin
      if (rst_after > 0 && cyc == c + rst_after) begin
        rst = 1; in_valid = 0; w_wr_en = 0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        return;
      end
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        w_wr_en   = 1'($urandom_range(0, 1));
        w_wr_idx  = IW'($urandom_range(0, (1 << IW) - 1));
        w_wr_data = {$urandom, $urandom};
        in_target = 1'($urandom_range(0, 1));
        lr        = {$urandom, $urandom};
        in_x      = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
    end
    in_valid = 0; w_wr_en = 0;
    if (upd)
      for (int i = 0; i < NW; i++) mw[i] += (i < N) ? fmul(lr_err, sx[i]) : lr_err;
    check_weights();
  endtask

  function automatic longint rnd_sfp();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 0;
      default: return longint'(int'($urandom)) <<< 3;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    mon_en = 1;
    check_weights();

    // First training step from zero weights
    sx = '{ONE, ONE};
    run_sample(0, 1, ONE / 2, 0, 0, 0, 0, 0);
    chk("s2_acc", acc, 64'd0);
    chk("s2_y", 64'(y), 64'd1);
    rd(0, "s2_w0", 64'hFFFFFFFF80000000);
    rd(1, "s2_w1", 64'hFFFFFFFF80000000);
    chk("s2_err_cnt", 64'(err_cnt), 64'd1);

    // Same sample again: now classified correctly
    run_sample(0, 1, ONE / 2, 0, 0, 0, 0, 0);
`ifdef PERCEPTRON_BIAS_EN
    chk("s3_acc", acc, 64'hFFFFFFFE80000000);
`else
    chk("s3_acc", acc, 64'hFFFFFFFF00000000);
`endif
    chk("s3_y", 64'(y), 64'd0);
    chk("s3_err_cnt", 64'(err_cnt), 64'd1);

    // Inference only
    preload(0, 2 * ONE);
    preload(1, -ONE);
    if (NW > N) preload(NW - 1, 0);
    sx = '{ONE / 2, 3 * ONE};
    run_sample(1, 0, ONE, 0, 0, 0, 0, 0);
    chk("s4_acc", acc, 64'hFFFFFFFE00000000);
    chk("s4_y", 64'(y), 64'd0);
    chk("s4_err_cnt", 64'(err_cnt), 64'd2);
    rd(0, "s4_w0", 64'h0000000200000000);
    rd(1, "s4_w1", 64'hFFFFFFFF00000000);

    // Writes while busy are ignored; write on the accept cycle is used
    sx = '{ONE, ONE};
    run_sample(1, 1, ONE / 4, 0, 0, 0, 0, 1);
    for (int i = 0; i < NW; i++) preload(i, 0);
    sx = '{ONE, 0};
    run_sample(1, 0, ONE, 1, 0, ONE, 0, 0);
    chk("s5_acc", acc, 64'h0000000100000000);

    // Reset mid-Compute, then mid-Update
    sx = '{ONE, ONE};
    run_sample(0, 1, ONE, 0, 0, 0, 1, 0);
    chk("s1_err_cnt", 64'(err_cnt), 64'd0);
    check_weights();
    preload(0, ONE);
    run_sample(0, 1, ONE, 0, 0, 0, T + 1, 0);
    check_weights();

`ifdef PERCEPTRON_BIAS_EN
    preload(NW - 1, -ONE / 4);
    sx = '{0, 0};
    run_sample(0, 0, ONE, 0, 0, 0, 0, 0);
    chk("s6_acc", acc, 64'hFFFFFFFFC0000000);
    chk("s6_y", 64'(y), 64'd0);
`endif

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0)
        preload(int'($urandom_range(0, (1 << IW) - 1)), rnd_sfp());
      for (int i = 0; i < N; i++) sx[i] = rnd_sfp();
      run_sample(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 longint'($urandom), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, (1 << IW) - 1)), rnd_sfp(),
                 ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 2 * T)) : 0,
                 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/perceptron_train_ctrl.md
# perceptron_train_ctrl

Sequencing controller for a single fixed-point perceptron with online training. It accepts one sample per handshake and runs the dot product on one shared fixed-point multiplier, one term per cycle. It applies the Step activation and emits the result, then performs the error-driven weight update with the same multiplier. It sits between the sample/label stream and the perceptron weight store, using the `sfp` fixed-point arithmetic and the `train_state` sequencing enum.

## Interface
Parameters:
- `N_INPUTS`, default 4: number of inputs and weights (≥1).
- `IDX_W`, default `$clog2(N_INPUTS+1)`: index width.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: sample offered.
- `in_ready`, output, 1: high only in Idle.
- `in_x`, input, `N_INPUTS*64`: input vector, `x[i]` at bits `[64*i+63:64*i]`, each `sfp`.
- `in_target`, input, 1: label; 0 means 0.0, 1 means 1.0.
- `in_train`, input, 1: perform the update phase.
- `lr`, input, 64: learning rate (`sfp`), sampled at accept.
- `w_wr_en`, input, 1: weight preload strobe, honoured only in Idle.
- `w_wr_idx`, input, `IDX_W`: weight index to write.
- `w_wr_data`, input, 64: weight value to write.
- `w_rd_idx`, input, `IDX_W`: weight index to read.
- `w_rd_data`, output, 64: combinational read of the weight at `w_rd_idx`; reads 0 for an out-of-range index.
- `y_valid`, output, 1: one-cycle result pulse.
- `y`, output, 1: Step output.
- `acc`, output, 64: final weighted sum, registered.
- `err_cnt`, output, 32: count of samples with nonzero error; wraps.
- `busy`, output, 1: state is not Idle.

## Operation
- Sequencing uses `train_state` with states Idle, Compute and Update.
- **Idle.** A sample is accepted when `in_valid && in_ready`. On accept, latch x, target, train and `lr`, clear the accumulator, set `idx=0` and go to Compute.
- **Compute.** Each cycle: `acc_r ← acc_r + sfp_mul(w[idx], x[idx])`, then `idx++`.
  - After term `T-1`, leave Compute. T is `N_INPUTS`, or `N_INPUTS+1` with bias.
  - On that leaving edge, register `y = (sum ≥ 0)`, where the sum includes the final term. Also register `acc`, and pulse `y_valid` for one cycle.
  - Error: `err = target − y`, which is one of −1.0, 0 or +1.0.
  - If `err ≠ 0`, increment `err_cnt`, regardless of `in_train`.
  - If `in_train && err ≠ 0`, compute `lr_err = sfp_mul(lr, err)`, set `idx=0` and go to Update. Otherwise go to Idle.
- **Update.** Each cycle: `w[idx] ← w[idx] + sfp_mul(lr_err, x[idx])`, then `idx++`. After `T` cycles, go to Idle.
- **Arithmetic.** Additions wrap at 64-bit two's complement; there is no saturation. Multiplies use `sfp_mul`: arithmetic shift right by 32, keeping the low 64 bits.
- **Preload.** A preload write is ignored outside Idle. An out-of-range `w_wr_idx` is ignored.
- **Simultaneous write and accept.** If a preload write and a sample accept occur in the same Idle cycle, the write commits and the sample's Compute uses the new value.
- **Reset.** Reset at any point, including mid-Compute or mid-Update, forces:
  - state Idle, all weights 0, accumulator 0;
  - `y=0`, `y_valid=0`, `acc=0`, `err_cnt=0`, `busy=0`, `in_ready=1`;
  - no partial update survives.

## Timing
- Accept edge is cycle 0. Compute runs in cycles 1..T.
- `y_valid` is high in cycle T+1 only.
- Without update, state is Idle and `in_ready=1` in cycle T+1, so back-to-back throughput is one sample per T+1 cycles.
- With update, Update runs in cycles T+1..2T and Idle resumes in cycle 2T+1.
- `in_ready` and `busy` are combinational from state. Every other output is registered.
- Weights written in Update are visible on `w_rd_data` in the following cycle.

## Configuration
- `PERCEPTRON_BIAS_EN` defined:
  - adds a bias weight at index `N_INPUTS`, with an implicit input of 1.0, so T = `N_INPUTS+1`;
  - the bias is preloadable and readable at index `N_INPUTS`;
  - the bias update is `w_b += lr_err`.
- Undefined: no bias, T = `N_INPUTS`, and index `N_INPUTS` is out of range.

## Structure
- Use the `FixedPoint` package (`sfp`, `sfp_mul`, `sfp_add`, `frac_bits`) and `Common::train_state`.
- Add `sfp_one = int_to_sfp(1)` to `FixedPoint`.
- Add an activation-select hook to `Common`; only Step is implemented here.
- One sub-module, `sfp_mac`: a combinational `a + sfp_mul(b, c)`. It is shared by the Compute and Update phases through operand muxes.

## Test plan
All scenarios use `N_INPUTS=2` and no bias unless stated.
1. **Reset mid-operation.**
   - Stimulus: assert `rst` mid-Compute.
   - Response: next cycle is Idle, `in_ready=1`, `y_valid=0`, `err_cnt=0`, `w_rd_data=0` for all indices.
2. **First training step.**
   - Stimulus: weights 0, `x=(1.0,1.0)`, `target=0`, `train=1`, `lr=0.5`.
   - Response: `y_valid` in cycle 3 with `y=1` and `acc=0`; Update in cycles 3–4; weights become `(−0.5,−0.5)` (`'hFFFFFFFF80000000`); `err_cnt=1`; Idle in cycle 5.
3. **Repeat sample, no error.**
   - Stimulus: repeat scenario 2's sample.
   - Response: `acc=−1.0`, `y=0`, no Update, `in_ready` high in cycle 3, `err_cnt` stays 1.
4. **Inference only.**
   - Stimulus: preload `w=(2.0,−1.0)`, `x=(0.5,3.0)`, `train=0`, `target=1`.
   - Response: `acc=−2.0`, `y=0`, `err_cnt` increments, weights unchanged.
5. **Writes outside Idle, write-plus-accept.**
   - Stimulus: `w_wr_en` pulsed during Compute and Update.
   - Response: weights unaffected.
   - Stimulus: write `w[0]=1.0` in the same cycle as accept, with zero weights and `x=(1.0,0)`.
   - Response: `acc=1.0`.
6. **Bias enabled.**
   - Stimulus: `PERCEPTRON_BIAS_EN`, bias preloaded to −0.25, `x=(0,0)`.
   - Response: `acc=−0.25`, `y_valid` in cycle 4, `y=0`.
